// File: rtl/fp_mul_mant_seq.sv
// Iterative mantissa multiplier front end for the FP multiply path.
// Define FP_MUL_RADIX4_EN to retire two multiplier bits per CALC cycle.
module fp_mul_mant_seq #(
  parameter int BUS_WIDTH = 64,
  localparam int MANT = (BUS_WIDTH == 64) ? 52 : 23,
  localparam int EXP = (BUS_WIDTH == 64) ? 11 : 8,
  localparam int BIAS = (BUS_WIDTH == 64) ? 1023 : 127,
  localparam int PW = 2 * MANT + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] N1,
  input  logic [BUS_WIDTH-1:0] N2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign_out,
  output logic [EXP+1:0]       exp_sum,
  output logic [PW-1:0]        product,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_nan
);

  localparam int MW = MANT + 1;
`ifdef FP_MUL_RADIX4_EN
  localparam int R = 2;
`else
  localparam int R = 1;
`endif
  localparam int ITER = (MW + R - 1) / R;
  localparam int MPW = ITER * R;
  localparam int AW = MPW + MW;
  localparam int SW = MW + R;
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic            s1, s2;
  logic [EXP-1:0]  e1, e2;
  logic [MANT-1:0] m1, m2;

  assign {s1, e1, m1} = N1;
  assign {s2, e2, m2} = N2;

  logic z1, z2, i1, i2, n1, n2;
  logic nan_c, inf_c, zero_c, spec_c;

  always_comb begin
    z1 = (e1 == '0);
    z2 = (e2 == '0);
    i1 = (&e1) && (m1 == '0);
    i2 = (&e2) && (m2 == '0);
    n1 = (&e1) && (m1 != '0);
    n2 = (&e2) && (m2 != '0);
    nan_c = n1 | n2 | (z1 & i2) | (z2 & i1);
    inf_c = (i1 | i2) & ~nan_c;
    zero_c = (z1 | z2) & ~nan_c;
    spec_c = z1 | z2 | i1 | i2 | n1 | n2;
  end

  logic [EXP+1:0] exp_c;
  assign exp_c = (EXP+2)'(e1) + (EXP+2)'(e2) - (EXP+2)'(BIAS);

  logic [MW-1:0]  mc;
  logic [MPW-1:0] mp;
  logic [AW-1:0]  acc, acc_nx;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  addend, sum;
  logic           sign_r, zero_r, inf_r, nan_r;
  logic [EXP+1:0] exp_r;

`ifdef FP_MUL_RADIX4_EN
  logic [SW-1:0] mc3;

  always_comb begin
    addend = '0;
    unique case (mp[1:0])
      2'd1:    addend = SW'(mc);
      2'd2:    addend = SW'({mc, 1'b0});
      2'd3:    addend = mc3;
      default: addend = '0;
    endcase
  end
`else
  assign addend = mp[0] ? SW'(mc) : '0;
`endif

  // add into the upper half, then shift the whole accumulator down
  assign sum = SW'(acc[AW-1:MPW]) + addend;
  assign acc_nx = {sum, acc[MPW-1:R]};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = spec_c ? DONE : CALC;
      CALC: if (cnt == CW'(ITER - 1)) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc <= '0;
      mp <= '0;
      acc <= '0;
      cnt <= '0;
      sign_r <= 1'b0;
      exp_r <= '0;
      zero_r <= 1'b0;
      inf_r <= 1'b0;
      nan_r <= 1'b0;
`ifdef FP_MUL_RADIX4_EN
      mc3 <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= s1 ^ s2;
            zero_r <= zero_c;
            inf_r <= inf_c;
            nan_r <= nan_c;
            exp_r <= spec_c ? '0 : exp_c;
            acc <= '0;
            cnt <= '0;
            mc <= {1'b1, m1};
            mp <= MPW'({1'b1, m2});
`ifdef FP_MUL_RADIX4_EN
            mc3 <= SW'({1'b1, m1}) + SW'({1'b1, m1, 1'b0});
`endif
          end
        end
        CALC: begin
          acc <= acc_nx;
          mp <= mp >> R;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // radix-4 on an odd width leaves a spare always-zero top bit
  logic unused_hi;
  assign unused_hi = ^acc[AW-1:PW-1];

  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sign_out = sign_r;
  assign exp_sum = exp_r;
  assign product = acc[PW-1:0];
  assign is_zero = zero_r & out_valid;
  assign is_inf = inf_r & out_valid;
  assign is_nan = nan_r & out_valid;

endmodule

// File: tb/tb_fp_mul_mant_seq.sv
// Scoreboard bench for fp_mul_mant_seq (64-bit build).
// Expected results come from a plain-arithmetic IEEE-754 model.
module tb_fp_mul_mant_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [63:0] N1 = '0;
  logic [63:0] N2 = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic sign_out;
  logic [12:0] exp_sum;
  logic [105:0] product;
  logic is_zero, is_inf, is_nan;

  always #5 clk = ~clk;

  fp_mul_mant_seq #(.BUS_WIDTH(64)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .N1(N1),
    .N2(N2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sign_out(sign_out),
    .exp_sum(exp_sum),
    .product(product),
    .is_zero(is_zero),
    .is_inf(is_inf),
    .is_nan(is_nan)
  );

`ifdef FP_MUL_RADIX4_EN
  localparam int LAT_N = 28;
`else
  localparam int LAT_N = 54;
`endif

  typedef struct {
    logic s;
    logic [12:0] e;
    logic [105:0] p;
    logic z, i, n;
    int lat;
    int acc_edge;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit hold = 0;
  bit rnd_rdy = 0;
  bit seen = 0;
  bit chk_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
    exp_t r;
    logic [10:0] ea, eb;
    logic [51:0] ma, mb;
    logic za, zb, ia, ib, na, nb;
    logic [105:0] fa, fb;
    ea = a[62:52];
    eb = b[62:52];
    ma = a[51:0];
    mb = b[51:0];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 11'h7FF) && (ma == 0);
    ib = (eb == 11'h7FF) && (mb == 0);
    na = (ea == 11'h7FF) && (ma != 0);
    nb = (eb == 11'h7FF) && (mb != 0);
    r.s = a[63] ^ b[63];
    r.n = na | nb | (za & ib) | (zb & ia);
    r.i = (ia | ib) & ~r.n;
    r.z = (za | zb) & ~r.n;
    r.acc_edge = 0;
    if (za | zb | ia | ib | na | nb) begin
      r.p = '0;
      r.e = '0;
      r.lat = 1;
    end else begin
      fa = 106'(ma) + (106'(1) << 52);
      fb = 106'(mb) + (106'(1) << 52);
      r.p = fa * fb;
      r.e = 13'(int'(ea) + int'(eb) - 1023);
      r.lat = LAT_N;
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [10:0] e;
    logic [51:0] m;
    int k;
    k = $urandom_range(0, 9);
    m = 52'({$urandom(), $urandom()});
    if (k == 0) e = '0;
    else if (k == 1) begin
      e = 11'h7FF;
      if ($urandom_range(0, 1) == 1) m = '0;
    end else e = 11'($urandom_range(1, 2046));
    return {1'($urandom()), e, m};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold) out_ready = 1'b0;
      else if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
      chk_rdy = 0;
    end else begin
      if (chk_rdy) begin
        chk("ready_after_handoff", in_ready, 1);
        chk_rdy = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid: got 1 want 0");
        end else begin
          cur = q[0];
          chk("sign", sign_out, cur.s);
          chk("exp_sum", exp_sum, cur.e);
          chk("product", product, cur.p);
          chk("is_zero", is_zero, cur.z);
          chk("is_inf", is_inf, cur.i);
          chk("is_nan", is_nan, cur.n);
          chk("in_ready_busy", in_ready, 0);
          if (!seen) chk("latency", cyc - cur.acc_edge + 1, cur.lat);
          seen = 1;
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
            chk_rdy = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input bit junk);
    exp_t e;
    int n;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    N1 = a;
    N2 = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
      in_valid = 1'b0;
      return;
    end
    e = model(a, b);
    e.acc_edge = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #2;
    if (junk) begin
      N1 = rnd_op();
      N2 = rnd_op();
      repeat (3) @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  logic [63:0] dir_a[7];
  logic [63:0] dir_b[7];

  initial begin
    int n;
    dir_a = '{64'h3FF8000000000000, 64'h3FFFFFFFFFFFFFFF,
              64'h7FF0000000000000, 64'hFFF0000000000000,
              64'h0010000000000000, 64'h8000000000000000,
              64'h7FF8000000000000};
    dir_b = '{64'h4000000000000000, 64'h3FFFFFFFFFFFFFFF,
              64'h0000000000000000, 64'h3FF0000000000000,
              64'h0010000000000000, 64'h4000000000000000,
              64'h3FF0000000000000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sign", sign_out, 0);
    chk("rst_exp", exp_sum, 0);
    chk("rst_product", product, 0);
    chk("rst_flags", {is_zero, is_inf, is_nan}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(dir_a[i], dir_b[i], i < 2);
      drain();
    end

    hold = 1;
    send(64'h3FF8000000000000, 64'hC000000000000000, 0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", out_valid, 1);
    repeat (10) @(negedge clk);
    hold = 0;
    drain();

    send(64'h4000000000000000, 64'h4000000000000000, 0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_product", product, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    send(64'h4000000000000000, 64'h4000000000000000, 0);
    drain();

    rnd_rdy = 1;
    repeat (60) send(rnd_op(), rnd_op(), 0);
    drain();
    rnd_rdy = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_mant_seq.md
Name: fp_mul_mant_seq

Overview:
- Iterative, handshaked pre-stage of the FP multiplier datapath.
- Accepts a raw IEEE-754 operand pair and unpacks sign, exponent and mantissa.
- Screens special operands, computes the unbiased exponent sum and forms the full mantissa product with a shift-add engine.
- Hands the sign, exponent, product and special flags to the downstream normalize/round stage; replaces the single-cycle 53x53 array multiply.

Parameters:
- BUS_WIDTH, 64, operand width; 64 selects double (MANT=52, EXP=11, BIAS=1023), 32 selects single (MANT=23, EXP=8, BIAS=127).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- N1  in  BUS_WIDTH  operand A, IEEE-754
- N2  in  BUS_WIDTH  operand B, IEEE-754
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sign_out  out  1  S1 xor S2
- exp_sum  out  EXP+2  two's-complement E1+E2-BIAS
- product  out  2*MANT+2  {1,M1}*{1,M2}; binary point sits between bits 2*MANT and 2*MANT-1
- is_zero  out  1  result is zero
- is_inf  out  1  result is infinity
- is_nan  out  1  result is NaN

Behaviour:
- Reset values: FSM=IDLE; in_ready=1; out_valid=0; sign_out, exp_sum, product and all flags = 0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, register the unpacked fields. Go to DONE if the operand pair is special, otherwise go to CALC.
  - CALC: in_ready=0. Run ITER=MANT+1 cycles. Each cycle, if multiplier LSB=1, add the multiplicand to the upper half of the accumulator; then shift the accumulator and multiplier right by 1. An iteration counter counts 0..ITER-1; at ITER-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE. All outputs stay stable while out_ready=0.
- Operand classes (denormals are flushed to zero):
  - zero: E==0
  - inf: E==all-ones and M==0
  - nan: E==all-ones and M!=0
- Special pair: either operand is in the zero, inf or nan class.
  - is_nan = either operand nan, OR (zero and inf).
  - is_inf = (either inf) and not is_nan.
  - is_zero = (either zero) and not is_nan.
  - For a special pair, product=0 and exp_sum=0. Flags are driven only from DONE.
- Latency:
  - Normal pair: out_valid rises ITER+1 cycles after the accept edge (54 for 64-bit, 25 for 32-bit).
  - Special pair: out_valid rises 1 cycle after the accept edge.
- Throughput: one operation in flight. No accept is allowed in the same cycle as a result handoff; the next accept can occur 1 cycle after the handoff.
- Width rules:
  - exp_sum is computed at EXP+2 bits, sign-extended.
  - The value is not clamped; overflow and underflow detection is the downstream stage's job.
  - product is exact, with no truncation.
- rst asserted in any state returns to reset values on the next edge; any in-flight operation is discarded silently.
- in_valid asserted while in_ready=0 is ignored; N1 and N2 are not sampled.

Optional Feature:
- Macro: FP_MUL_RADIX4_EN.
- Defined: CALC retires 2 multiplier bits per cycle (add 0/1/2/3 x multiplicand, with 3x precomputed on accept). ITER=ceil((MANT+1)/2): 27 for 64-bit, 12 for 32-bit. Normal-pair latency becomes ITER+1.
- Undefined: radix-2 as above.
- Outputs, flags and handshake are identical in both builds; only cycle counts differ.

Test Plan:
- Basic multiply (64-bit): N1=0x3FF8000000000000, N2=0x4000000000000000 -> after 54 cycles: out_valid=1, sign_out=0, exp_sum=1024, product=3<<103, all flags 0.
- Maximum mantissas: N1=N2=0x3FFFFFFFFFFFFFFF -> exp_sum=1023, product=2^106-2^54+1.
- Special pairs:
  - N1=0x7FF0000000000000, N2=0 -> out_valid 1 cycle after accept, is_nan=1, product=0.
  - N1=0xFFF0000000000000, N2=0x3FF0000000000000 -> is_inf=1, sign_out=1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout. Raise out_ready -> handoff, in_ready=1 on the next cycle.
- Reset mid-operation: rst pulsed at CALC cycle 20 -> out_valid=0, in_ready=1 on the next cycle. A following 0x4000000000000000 x 0x4000000000000000 gives exp_sum=1025, product=1<<104.
- Underflow passthrough: N1=N2=0x0010000000000000 -> exp_sum=-1021 (13-bit two's complement), is_zero=0.
